// File: rtl/regread_stage_pkg.sv
// Shared constants and types for the operand-fetch stage and its decode/execute neighbours.
package regread_stage_pkg;
  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [CTRL_W-1:0]    ctrl_t;
  typedef logic [NREGS-1:0]     reg_mask_t;

  // One-hot register mask; x0 never appears in it.
  function automatic reg_mask_t idx_onehot(input reg_idx_t idx);
    reg_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    m[0]   = 1'b0;
    return m;
  endfunction

  function automatic logic wb_hits(input logic wen, input reg_idx_t waddr, input reg_idx_t idx);
    return wen && (waddr == idx) && (idx != '0);
  endfunction
endpackage

// File: rtl/regread_stage_rf_scoreboard.sv
// Pending-write mask for in-flight destinations, with two source taps and one WAW tap.
module rf_scoreboard
  import regread_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rd_idx0,
  input  logic [REG_IDX_W-1:0] rd_idx1,
  input  logic [REG_IDX_W-1:0] waw_idx,
  output logic                 pend0,
  output logic                 pend1,
  output logic                 pend_waw
);
  reg_mask_t pending_r;
  reg_mask_t set_mask_s;
  reg_mask_t clr_mask_s;
  reg_mask_t pending_nxt_s;

  // Next mask: clear first so a same-cycle set of the same bit wins.
  always_comb begin
    set_mask_s    = '0;
    clr_mask_s    = '0;
    if (set_en) begin
      set_mask_s = idx_onehot(set_idx);
    end else begin
      set_mask_s = '0;
    end
    if (clr_en) begin
      clr_mask_s = idx_onehot(clr_idx);
    end else begin
      clr_mask_s = '0;
    end
    pending_nxt_s = (pending_r & ~clr_mask_s) | set_mask_s;
  end

  // Pending mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  assign pend0    = pending_r[rd_idx0];
  assign pend1    = pending_r[rd_idx1];
  assign pend_waw = pending_r[waw_idx];
endmodule

// File: rtl/regread_stage.sv
// Operand-fetch stage: regfile read, same-cycle writeback forwarding, RAW/WAW stall,
// and a registered operand bundle toward execute over valid/ready.
module regread_stage
  import regread_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic [REG_IDX_W-1:0] in_rs2,
  input  logic                 in_use_rs1,
  input  logic                 in_use_rs2,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_rd_wen,
  input  logic [CTRL_W-1:0]    in_ctrl,
  output logic [REG_IDX_W-1:0] rf_raddr0,
  output logic [REG_IDX_W-1:0] rf_raddr1,
  input  logic [XLEN-1:0]      rf_rdata0,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic                 wb_wen,
  input  logic [REG_IDX_W-1:0] wb_waddr,
  input  logic [XLEN-1:0]      wb_wdata,
  input  logic                 squash,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [XLEN-1:0]      out_op0,
  output logic [XLEN-1:0]      out_op1,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_rd_wen,
  output logic [CTRL_W-1:0]    out_ctrl
);
  logic                 out_val_r;
  logic [XLEN-1:0]      op0_r;
  logic [XLEN-1:0]      op1_r;
  logic [REG_IDX_W-1:0] rd_r;
  logic                 rd_wen_r;
  ctrl_t                ctrl_r;

  logic                 fwd0_s, fwd1_s, fwd_rd_s;
  logic [XLEN-1:0]      op0_s, op1_s;
  logic                 pend0_s, pend1_s, pend_waw_s;
  logic                 held_rs1_s, held_rs2_s, held_rd_s;
  logic                 raw0_s, raw1_s, waw_s, hazard_s;
  logic                 in_rdy_s, in_fire_s, out_fire_s, sb_set_s;

  rf_scoreboard u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (sb_set_s),
    .set_idx  (rd_r),
    .clr_en   (wb_wen),
    .clr_idx  (wb_waddr),
    .rd_idx0  (in_rs1),
    .rd_idx1  (in_rs2),
    .waw_idx  (in_rd),
    .pend0    (pend0_s),
    .pend1    (pend1_s),
    .pend_waw (pend_waw_s)
  );

  assign rf_raddr0 = in_rs1;
  assign rf_raddr1 = in_rs2;

  // Writeback forwarding: the regfile does not bypass, so a same-cycle write is muxed in here.
  always_comb begin
    fwd0_s   = wb_hits(wb_wen, wb_waddr, in_rs1);
    fwd1_s   = wb_hits(wb_wen, wb_waddr, in_rs2);
    fwd_rd_s = wb_hits(wb_wen, wb_waddr, in_rd);
    op0_s    = fwd0_s ? wb_wdata : rf_rdata0;
    op1_s    = fwd1_s ? wb_wdata : rf_rdata1;
  end

  // Hazards: the held entry is not yet in the mask, so its rd is compared directly.
  always_comb begin
    held_rs1_s = out_val_r && rd_wen_r && (rd_r == in_rs1);
    held_rs2_s = out_val_r && rd_wen_r && (rd_r == in_rs2);
    held_rd_s  = out_val_r && rd_wen_r && (rd_r == in_rd);
    raw0_s     = in_use_rs1 && (in_rs1 != '0) && ((pend0_s && !fwd0_s) || held_rs1_s);
    raw1_s     = in_use_rs2 && (in_rs2 != '0) && ((pend1_s && !fwd1_s) || held_rs2_s);
    waw_s      = in_rd_wen && (in_rd != '0) && ((pend_waw_s && !fwd_rd_s) || held_rd_s);
    hazard_s   = raw0_s || raw1_s || waw_s;
    in_rdy_s   = reset_n && !hazard_s && !squash && (!out_val_r || out_rdy);
    in_fire_s  = in_val && in_rdy_s;
    out_fire_s = out_val_r && out_rdy;
    sb_set_s   = out_fire_s && !squash && rd_wen_r && (rd_r != '0);
  end

  // Operand bundle register: squash kills, input fire loads, output fire drains, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_val_r <= 1'b0;
      op0_r     <= '0;
      op1_r     <= '0;
      rd_r      <= '0;
      rd_wen_r  <= 1'b0;
      ctrl_r    <= '0;
    end else if (squash) begin
      out_val_r <= 1'b0;
    end else if (in_fire_s) begin
      out_val_r <= 1'b1;
      op0_r     <= op0_s;
      op1_r     <= op1_s;
      rd_r      <= in_rd;
      rd_wen_r  <= in_rd_wen;
      ctrl_r    <= in_ctrl;
    end else if (out_fire_s) begin
      out_val_r <= 1'b0;
    end else begin
      out_val_r <= out_val_r;
    end
  end

  assign in_rdy     = in_rdy_s;
  assign out_val    = out_val_r;
  assign out_op0    = op0_r;
  assign out_op1    = op1_r;
  assign out_rd     = rd_r;
  assign out_rd_wen = rd_wen_r;
  assign out_ctrl   = ctrl_r;
endmodule

// File: tb/tb_regread_stage.sv
// Randomized bench: program-order architectural model plus in-flight writer counts,
// with a scoreboard queue checked by an independent output monitor.
module tb_regread_stage;
  import regread_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_val, in_rdy;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_rd_wen;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_raddr0, rf_raddr1;
  logic [31:0] rf_rdata0, rf_rdata1;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        squash;
  logic        out_val, out_rdy;
  logic [31:0] out_op0, out_op1;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [15:0] out_ctrl;

  regread_stage dut (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_ctrl(in_ctrl),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .squash(squash),
    .out_val(out_val), .out_rdy(out_rdy), .out_op0(out_op0), .out_op1(out_op1),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2, wen;
    logic [15:0] ctrl;
    logic [31:0] op0, op1, result, prev;
  } ins_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } wb_t;

  ins_t sbq[$];
  wb_t  wbq[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Bench regfile: combinational read, x0 reads zero, no internal bypass.
  logic [31:0] rf [32];
  logic [31:0] init_vals [32];
  logic        rf_load;
  assign rf_rdata0 = (rf_raddr0 == 5'd0) ? 32'd0 : rf[rf_raddr0];
  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : rf[rf_raddr1];
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_vals[i];
    end else if (wb_wen && wb_waddr != 5'd0) begin
      rf[wb_waddr] <= wb_wdata;
    end
  end

  // Reference state
  logic [31:0] model_regs [32];
  int          inflight [32];
  logic [31:0] pend_m;
  bit          slot_full_m;
  ins_t        slot_m;
  ins_t        cur;
  bit          have_instr;
  logic [4:0]  last_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit busy(input logic [4:0] r);
    int hit;
    hit = (wb_wen && wb_waddr == r) ? 1 : 0;
    return (r != 5'd0) && (inflight[r] > hit);
  endfunction

  task automatic gen_instr();
    cur.rs1  = ($urandom_range(0, 3) == 0) ? last_rd : 5'($urandom_range(0, 7));
    cur.rs2  = 5'($urandom_range(0, 7));
    cur.rd   = 5'($urandom_range(0, 7));
    cur.use1 = ($urandom_range(0, 3) != 0);
    cur.use2 = ($urandom_range(0, 3) != 0);
    cur.wen  = ($urandom_range(0, 3) != 0);
    cur.ctrl = 16'($urandom);
    cur.op0  = model_regs[cur.rs1];
    cur.op1  = model_regs[cur.rs2];
    cur.result = $urandom;
    cur.prev = model_regs[cur.rd];
    if (cur.wen && cur.rd != 5'd0) model_regs[cur.rd] = cur.result;
    last_rd = cur.rd;
    have_instr = 1'b1;
  endtask

  // Output monitor: pops the oldest expected bundle on every output handshake.
  always @(negedge clk) begin
    ins_t e;
    if (reset_n && out_val && out_rdy) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL out_unexpected @cyc %0d: got out_val with rd %0d, expected no bundle", cyc, out_rd);
      end else begin
        e = sbq.pop_front();
        check("out_rd", 64'(out_rd), 64'(e.rd));
        check("out_rd_wen", 64'(out_rd_wen), 64'(e.wen));
        check("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
        if (e.use1) check("out_op0", 64'(out_op0), 64'(e.op0));
        if (e.use2) check("out_op1", 64'(out_op1), 64'(e.op1));
        if (e.wen) wbq.push_back('{rd: e.rd, data: e.result, due: cyc + int'($urandom_range(1, 3))});
      end
    end
  end

  initial begin
    wb_t  j;
    bit   exp_rdy, fire_m;
    reset_n = 1'b0; rf_load = 1'b1;
    in_val = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_rd_wen = 1'b0; in_ctrl = 16'd0;
    wb_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0; squash = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      init_vals[i]  = (i == 0) ? 32'd0 : $urandom;
      model_regs[i] = init_vals[i];
      inflight[i]   = 0;
    end
    pend_m = 32'd0; slot_full_m = 1'b0; have_instr = 1'b0; last_rd = 5'd1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", 64'(in_rdy), 64'd0);
    check("rst_out_val", 64'(out_val), 64'd0);
    check("rst_pending", 64'(dut.u_sb.pending_r), 64'd0);
    check("rst_out_op0", 64'(out_op0), 64'd0);
    check("rst_out_op1", 64'(out_op1), 64'd0);
    check("rst_out_rd", 64'({out_rd_wen, out_rd, out_ctrl}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rf_load = 1'b0;

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (wbq.size() > 0 && wbq[0].due <= cyc) begin
        j = wbq.pop_front();
        wb_wen = 1'b1; wb_waddr = j.rd; wb_wdata = j.data;
      end else begin
        wb_wen = 1'b0; wb_waddr = 5'($urandom_range(0, 31)); wb_wdata = $urandom;
      end
      squash  = 1'b0;
      out_rdy = ($urandom_range(0, 3) != 0);
      if (slot_full_m && !have_instr && $urandom_range(0, 15) == 0) begin
        squash  = 1'b1;
        out_rdy = 1'b0;
      end else if (!have_instr && $urandom_range(0, 3) != 0) begin
        gen_instr();
      end
      in_val = have_instr;
      if (have_instr) begin
        in_rs1 = cur.rs1; in_rs2 = cur.rs2; in_rd = cur.rd;
        in_use_rs1 = cur.use1; in_use_rs2 = cur.use2; in_rd_wen = cur.wen; in_ctrl = cur.ctrl;
      end else begin
        in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
        in_rd = 5'($urandom_range(0, 7)); in_use_rs1 = 1'($urandom);
        in_use_rs2 = 1'($urandom); in_rd_wen = 1'($urandom); in_ctrl = 16'($urandom);
      end

      @(negedge clk);
      exp_rdy = !squash && (!slot_full_m || out_rdy)
                && !(in_use_rs1 && busy(in_rs1))
                && !(in_use_rs2 && busy(in_rs2))
                && !(in_rd_wen && busy(in_rd));
      check("in_rdy", 64'(in_rdy), 64'(exp_rdy));
      check("out_val", 64'(out_val), 64'(slot_full_m));
      check("pending", 64'(dut.u_sb.pending_r), 64'(pend_m));

      fire_m = slot_full_m && out_rdy && !squash;
      if (wb_wen && wb_waddr != 5'd0) begin
        if (inflight[wb_waddr] > 0) inflight[wb_waddr]--;
        pend_m[wb_waddr] = 1'b0;
      end
      if (squash) begin
        slot_full_m = 1'b0;
        if (slot_m.wen && slot_m.rd != 5'd0) begin
          inflight[slot_m.rd]--;
          model_regs[slot_m.rd] = slot_m.prev;
        end
        if (sbq.size() > 0) sbq.delete(sbq.size() - 1);
      end else begin
        if (fire_m && slot_m.wen && slot_m.rd != 5'd0) pend_m[slot_m.rd] = 1'b1;
        if (in_val && exp_rdy) begin
          slot_full_m = 1'b1;
          slot_m = cur;
          sbq.push_back(cur);
          if (cur.wen && cur.rd != 5'd0) inflight[cur.rd]++;
          have_instr = 1'b0;
        end else if (fire_m) begin
          slot_full_m = 1'b0;
        end
      end
    end

    // Asynchronous reset mid-cycle with traffic in flight
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_val", 64'(out_val), 64'd0);
    check("async_rst_pending", 64'(dut.u_sb.pending_r), 64'd0);
    check("async_rst_in_rdy", 64'(in_rdy), 64'd0);
    check("async_rst_out_rd", 64'({out_rd_wen, out_rd}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
